streebog_session_arb: RTL
=========================

// Module: streebog_session_arb
// PURPOSE
//  - Shares one streebog_top hash core between NUM_REQ requesters; one whole hash session (start..digest) granted per requester at a time.
//  - Round-robin arbitration across sessions; routes the winner's message stream to the core, the digest back to the winner.
//  - Sits directly in front of streebog_top; drives its fsm_start_req/mes_*/hash_len inputs, consumes its ack/hash outputs.
// PARAMETERS
//  - NUM_REQ    4    number of requester channels (2..8)
//  - DATA_WIDTH 512  message/digest width; must match the core
//  - IDX_W      $clog2(NUM_REQ)  grant index width (derived, do not override)
// PORTS
//  - clk_i            in   1               clock, all logic on rising edge
//  - rstn_i           in   1               asynchronous reset, active-low
//  - sess_req_i       in   NUM_REQ         per-requester session request, held high until its digest is accepted
//  - hash_len_i       in   NUM_REQ         per-requester digest length select (1=512, 0=256)
//  - mes_valid_i      in   NUM_REQ         per-requester message beat valid
//  - mes_last_i       in   NUM_REQ         per-requester last beat flag
//  - mes_last_len_i   in   NUM_REQ*10      per-requester last-beat bit length, slice [10*k+:10]
//  - message_i        in   NUM_REQ*DATA_WIDTH  per-requester message beat, slice [DATA_WIDTH*k+:DATA_WIDTH]
//  - mes_ready_o      out  NUM_REQ         per-requester beat accept
//  - grant_o          out  NUM_REQ         one-hot current session owner, 0 when idle
//  - hash_o           out  DATA_WIDTH      digest (shared bus, qualified by hash_valid_o)
//  - hash_valid_o     out  NUM_REQ         digest valid to owner only
//  - hash_ready_i     in   NUM_REQ         per-requester digest accept
//  - core_start_req_o out  1               to core fsm_start_req_i
//  - core_start_ack_i in   1               from core fsm_start_ack_o
//  - core_hash_len_o  out  1               to core hash_len_i
//  - core_mes_valid_o / core_mes_last_o / core_mes_last_len_o[10] / core_message_o[DATA_WIDTH]  out  to core message port
//  - core_mes_ready_i in   1               from core mes_ready_o
//  - core_hash_i[DATA_WIDTH] / core_hash_valid_i  in   from core digest port
//  - core_hash_ready_o out 1               to core hash_ready_i
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, rr pointer=0, owner idx=0.
//  - FSM IDLE: if sess_req_i!=0 and core_start_ack_i==0, pick first set bit at/after pointer (wrap) -> latch idx, grant_o, core_hash_len_o=hash_len_i[idx] -> STREAM. 1 cycle decision latency.
//  - STREAM: core_start_req_o=1; combinational pass-through: core_mes_*=owner's mes_*, mes_ready_o[idx]=core_mes_ready_i, other mes_ready_o=0.
//    On owner beat with valid&ready&last -> DIGEST (next cycle core_mes_valid_o forced 0).
//  - DIGEST: core_start_req_o=1, core_mes_valid_o=0; hash_o=core_hash_i, hash_valid_o[idx]=core_hash_valid_i, core_hash_ready_o=hash_ready_i[idx].
//    valid&ready seen -> RELEASE.
//  - RELEASE: core_start_req_o=0, core_hash_ready_o=0, grant_o held; wait core_start_ack_i==0, then grant_o=0, pointer=idx+1 mod NUM_REQ -> IDLE.
//  - core_hash_len_o constant for whole session; later changes of hash_len_i[idx] ignored.
//  - sess_req_i[idx] dropped mid-session: ignored; session runs to digest (core cannot abort). Dropped in DIGEST before accept: arbiter keeps waiting.
//  - Non-owner mes_valid_i/hash_ready_i: ignored, never accepted.
//  - Simultaneous requests: strict rotation; a requester re-requesting right after its session waits behind all other pending requesters.
//  - core_hash_valid_i outside DIGEST: ignored (not forwarded).
//  - Reset asserted mid-session: all outputs 0 immediately; core is reset on same rstn_i.
// CONFIGURATION
//  - STREEBOG_ARB_STATS_EN defined: adds output sess_cnt_o [NUM_REQ*16], per-requester completed-session counter,
//    +1 on RELEASE->IDLE for idx, saturates at 16'hFFFF, reset 0.
//  - Not defined: port and counters absent; all other behaviour identical.
// TESTING
//  - Single req0, 1 beat last_len=0x1F8 -> one core session, digest routed to hash_valid_o[0] only, grant_o 0001->0.
//  - req0..3 all high at once, 2 beats each -> grants in order 0,1,2,3; no overlap of core_start_req_o sessions.
//  - req1 owns, req2 drives mes_valid_i=1 throughout -> mes_ready_o[2]=0 whole session, core sees only req1 data.
//  - Owner holds hash_ready_i=0 for 20 cycles -> hash_valid_o[idx] stays 1, FSM in DIGEST, no new grant.
//  - hash_len_i[0]=0 at grant then 1 mid-stream -> core_hash_len_o stays 0 to RELEASE.
//  - rstn_i low during STREAM -> all outputs 0 next edge; after release, fresh grant starts at requester 0.

Source files
------------

// File: rtl/streebog_session_arb.sv
// rtl/streebog_session_arb.sv - round-robin session arbiter sharing one streebog hash core; optional STREEBOG_ARB_STATS_EN adds sess_cnt_o
module streebog_session_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 512
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            sess_req_i,
    input  logic [NUM_REQ-1:0]            hash_len_i,
    input  logic [NUM_REQ-1:0]            mes_valid_i,
    input  logic [NUM_REQ-1:0]            mes_last_i,
    input  logic [NUM_REQ*10-1:0]         mes_last_len_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] message_i,
    output logic [NUM_REQ-1:0]            mes_ready_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [DATA_WIDTH-1:0]         hash_o,
    output logic [NUM_REQ-1:0]            hash_valid_o,
    input  logic [NUM_REQ-1:0]            hash_ready_i,
`ifdef STREEBOG_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]         sess_cnt_o,
`endif
    output logic                          core_start_req_o,
    input  logic                          core_start_ack_i,
    output logic                          core_hash_len_o,
    output logic                          core_mes_valid_o,
    output logic                          core_mes_last_o,
    output logic [9:0]                    core_mes_last_len_o,
    output logic [DATA_WIDTH-1:0]         core_message_o,
    input  logic                          core_mes_ready_i,
    input  logic [DATA_WIDTH-1:0]         core_hash_i,
    input  logic                          core_hash_valid_i,
    output logic                          core_hash_ready_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DIGEST,
        S_RELEASE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   pick;
    logic               found;
    int                 cand;
    logic [NUM_REQ-1:0] grant_q;
    logic               hash_len_q;
    logic               take;
    logic               last_beat;
    logic               digest_done;
    logic               release_done;

    // Search pending requesters starting at the rotation pointer, wrapping once.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && sess_req_i[IDX_W'(cand)]) begin
                found = 1'b1;
                pick  = IDX_W'(cand);
            end
        end
    end

    // Session event strobes. A new grant waits until the core has dropped its
    // acknowledge from the previous session so start handshakes never overlap.
    always_comb begin
        take         = (state == S_IDLE) && found && !core_start_ack_i;
        last_beat    = (state == S_STREAM) && mes_valid_i[idx] && core_mes_ready_i && mes_last_i[idx];
        digest_done  = (state == S_DIGEST) && core_hash_valid_i && hash_ready_i[idx];
        release_done = (state == S_RELEASE) && !core_start_ack_i;
    end

    // Session state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Session sequencing: grant, stream message, hand back digest, release core.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (take)         state_nxt = S_STREAM;
            S_STREAM:  if (last_beat)    state_nxt = S_DIGEST;
            S_DIGEST:  if (digest_done)  state_nxt = S_RELEASE;
            S_RELEASE: if (release_done) state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    // Owner index, grant vector, latched digest length and rotation pointer.
    // The pointer moves past the finished owner so it queues behind everyone else.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            idx        <= '0;
            ptr        <= '0;
            grant_q    <= '0;
            hash_len_q <= 1'b0;
        end else begin
            if (take) begin
                idx        <= pick;
                grant_q    <= NUM_REQ'(1) << pick;
                hash_len_q <= hash_len_i[pick];
            end
            if (release_done) begin
                grant_q <= '0;
                ptr     <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    assign grant_o         = grant_q;
    assign core_hash_len_o = hash_len_q;

    // Route the owner's message port to the core while streaming and the
    // core's digest port back to the owner while the digest is pending.
    always_comb begin
        mes_ready_o         = '0;
        hash_o              = '0;
        hash_valid_o        = '0;
        core_start_req_o    = 1'b0;
        core_mes_valid_o    = 1'b0;
        core_mes_last_o     = 1'b0;
        core_mes_last_len_o = '0;
        core_message_o      = '0;
        core_hash_ready_o   = 1'b0;
        case (state)
            S_STREAM: begin
                core_start_req_o    = 1'b1;
                core_mes_valid_o    = mes_valid_i[idx];
                core_mes_last_o     = mes_last_i[idx];
                core_mes_last_len_o = mes_last_len_i[10*idx +: 10];
                core_message_o      = message_i[DATA_WIDTH*idx +: DATA_WIDTH];
                mes_ready_o[idx]    = core_mes_ready_i;
            end
            S_DIGEST: begin
                core_start_req_o  = 1'b1;
                hash_o            = core_hash_i;
                hash_valid_o[idx] = core_hash_valid_i;
                core_hash_ready_o = hash_ready_i[idx];
            end
            default: begin
            end
        endcase
    end

`ifdef STREEBOG_ARB_STATS_EN
    logic [NUM_REQ*16-1:0] cnt_q;

    // Per-requester completed-session counters, saturating.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (release_done && (cnt_q[16*idx +: 16] != 16'hFFFF)) begin
            cnt_q[16*idx +: 16] <= cnt_q[16*idx +: 16] + 16'd1;
        end
    end

    assign sess_cnt_o = cnt_q;
`endif

endmodule
